// File: rtl/mips_program_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words and writes them from word 0, holding the CPU in reset until the image is complete.
// Latency: one cycle from the 4th accepted byte of a word to its mem_we pulse; cpu_reset drops one cycle after the last write (or checksum accept).
// Backpressure: in_ready is a pure function of state (no dependence on in_valid); memory writes never stall the stream.
// Optional: define MIPS_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK state).
module mips_program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef MIPS_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RUN,
        S_ERROR
    } state_t;

    // Largest legal word count: the whole memory.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t            state;
    state_t            state_nx;
    logic [7:0]        len_hi;
    logic [ADDR_W:0]   n_len;
    logic [23:0]       sr;
    logic [1:0]        bcnt;
    logic              accept;
    logic [16:0]       len_full;
    logic              len_bad;
    logic [ADDR_W:0]   wl_inc;
    logic              last_word;
    logic              word_done;
`ifdef MIPS_LOADER_CHECKSUM_EN
    logic [7:0]        xsum;
    logic              chk_ok;
`endif

    assign accept    = in_valid && in_ready;
    // Length as seen on the LEN_LO accept: high byte already latched, low byte on the bus.
    assign len_full  = {1'b0, len_hi, in_data};
    assign len_bad   = (len_full == 17'd0) || (len_full > CAPACITY);
    assign wl_inc    = words_loaded + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word = (wl_inc == n_len);
    assign word_done = accept && (bcnt == 2'd3);
`ifdef MIPS_LOADER_CHECKSUM_EN
    assign chk_ok    = (in_data == xsum);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and in_ready generation.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && (bcnt == 2'd3) && last_word) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
                    state_nx = S_CHK;
`else
                    state_nx = S_RUN;
`endif
                end
            end
`ifdef MIPS_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = chk_ok ? S_RUN : S_ERROR;
            end
`endif
            S_RUN: begin
                if (start) state_nx = S_LEN_HI;
            end
            S_ERROR: begin
                if (start) state_nx = S_LEN_HI;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs; reset discards any partial word and a write due on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len_hi       <= '0;
            n_len        <= '0;
            sr           <= '0;
            bcnt         <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        cpu_reset    <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        bcnt         <= '0;
                    end else if (state == S_RUN && !done) begin
                        // First RUN cycle: last word is already in memory, let the CPU go.
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) len_hi <= in_data;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        if (len_bad) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            n_len <= len_full[ADDR_W:0];
                            bcnt  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        sr   <= {sr[15:0], in_data};
                        bcnt <= bcnt + 2'd1;
                    end
                    if (word_done) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= words_loaded[ADDR_W-1:0];
                        mem_wdata    <= {sr, in_data};
                        words_loaded <= wl_inc;
                    end
                end
`ifdef MIPS_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept && !chk_ok) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef MIPS_LOADER_CHECKSUM_EN
    // Running XOR of every accepted byte of the current load, length bytes included.
    always_ff @(posedge clk) begin
        if (reset) begin
            xsum <= '0;
        end else if ((state == S_IDLE || state == S_RUN || state == S_ERROR) && start) begin
            xsum <= '0;
        end else if (accept) begin
            xsum <= xsum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_mips_program_loader.sv
module tb_mips_program_loader;

    localparam int ADDR_W = 10;
`ifdef MIPS_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    mips_program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {22'd0, mem_addr}, {22'd0, e.addr});
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    // Drive a byte stream from a negedge; optional idle cycle after each byte.
    task automatic send(input bq_t bytes, input bit gaps, input bit add_chk);
        logic [7:0] x;
        int         tmo;
        x = 8'h00;
        foreach (bytes[i]) x ^= bytes[i];
        if (add_chk && CHK_EN) bytes.push_back(x);
        foreach (bytes[i]) begin
            in_valid = 1'b1;
            in_data  = bytes[i];
            tmo      = 0;
            while (in_ready !== 1'b1 && tmo < 20) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 20) begin
                n_total++;
                $display("FAIL send_timeout: byte %0d in_ready %b expected 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (gaps) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t big;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words", words_loaded, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);

        // Two-word load, continuous valid
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 1);
        push_wr(10'd0, 32'h2009_0005);
        push_wr(10'd1, 32'h200A_000A);
        send({8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h05, 8'h20, 8'h0A, 8'h00, 8'h0A}, 1'b0, 1'b1);
        check("t1_cpu_held", cpu_reset, 1);
        check("t1_not_done", done, 0);
        @(negedge clk);
        check("t1_cpu_reset", cpu_reset, 0);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_words", words_loaded, 2);
        check("t1_q_empty", exp_q.size(), 0);

        // Reload from RUN
        pulse_start();
        check("t5_cpu_reset", cpu_reset, 1);
        check("t5_done", done, 0);
        check("t5_words_clr", words_loaded, 0);
        push_wr(10'd0, 32'h0800_0000);
        send({8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1);
        @(negedge clk);
        check("t5_done_end", done, 1);
        check("t5_words", words_loaded, 1);
        check("t5_q_empty", exp_q.size(), 0);

        // Backpressure: valid low every other cycle
        pulse_start();
        push_wr(10'd0, 32'h2009_0005);
        push_wr(10'd1, 32'h200A_000A);
        send({8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h05, 8'h20, 8'h0A, 8'h00, 8'h0A}, 1'b1, 1'b1);
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_cpu_reset", cpu_reset, 0);
        check("t2_words", words_loaded, 2);
        check("t2_q_empty", exp_q.size(), 0);

        // Bad lengths
        pulse_start();
        send({8'h00, 8'h00}, 1'b0, 1'b0);
        check("t3a_error", error, 1);
        check("t3a_cpu_reset", cpu_reset, 1);
        check("t3a_busy", busy, 0);
        check("t3a_in_ready", in_ready, 0);
        pulse_start();
        check("t3_err_clr", error, 0);
        send({8'h04, 8'h01}, 1'b0, 1'b0);
        check("t3b_error", error, 1);
        pulse_start();
        push_wr(10'd0, 32'hDEAD_BEEF);
        send({8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0, 1'b1);
        @(negedge clk);
        check("t3c_error", error, 0);
        check("t3c_done", done, 1);
        check("t3c_words", words_loaded, 1);

        // Full memory: N = 1024, last address all-ones
        big = {8'h04, 8'h00};
        for (int i = 0; i < 1024; i++) begin
            big.push_back(8'hA5);
            big.push_back(8'h00);
            big.push_back(8'(i >> 8));
            big.push_back(8'(i));
            push_wr(10'(i), 32'hA500_0000 | 32'(i));
        end
        pulse_start();
        send(big, 1'b0, 1'b1);
        @(negedge clk);
        check("full_done", done, 1);
        check("full_words", words_loaded, 1024);
        check("full_last_addr", mem_addr, 10'h3FF);
        check("full_q_empty", exp_q.size(), 0);

        // Reset mid-load, with the 4th data byte presented on the reset edge
        pulse_start();
        send({8'h00, 8'h01, 8'h20, 8'h09, 8'h00}, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h05;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("t4_cpu_reset", cpu_reset, 1);
        check("t4_busy", busy, 0);
        check("t4_in_ready", in_ready, 0);
        check("t4_mem_we", mem_we, 0);
        check("t4_words", words_loaded, 0);
        repeat (3) @(negedge clk);
        check("t4_in_ready_idle", in_ready, 0);
        pulse_start();
        push_wr(10'd0, 32'h2009_0005);
        send({8'h00, 8'h01, 8'h20, 8'h09, 8'h00, 8'h05}, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_reload_done", done, 1);
        check("t4_q_empty", exp_q.size(), 0);

`ifdef MIPS_LOADER_CHECKSUM_EN
        // Checksum good and bad
        pulse_start();
        push_wr(10'd0, 32'h1122_3344);
        send({8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 1'b0, 1'b0);
        @(negedge clk);
        check("t6a_done", done, 1);
        check("t6a_error", error, 0);
        pulse_start();
        push_wr(10'd0, 32'h1122_3344);
        send({8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46}, 1'b0, 1'b0);
        check("t6b_error", error, 1);
        check("t6b_cpu_reset", cpu_reset, 1);
        @(negedge clk);
        check("t6b_done", done, 0);
        check("t6_q_empty", exp_q.size(), 0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
